// File: rtl/fir_axis_param_if.sv
// AXI-Stream bundle shared by the FIR input and output ports.
// W is the tdata width; tstrb carries one bit per tdata byte.
interface fir_axis_param_if #(
    parameter int W = 16
) ();
    logic [W-1:0]   tdata;
    logic           tvalid;
    logic           tlast;
    logic [W/8-1:0] tstrb;
    logic           tready;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tstrb,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tstrb,
        output tready
    );
endinterface

// File: rtl/fir_axis_param.sv
// Transposed-form FIR filter between two AXI-Stream ports.
// Coefficients are written at run time through the cfg_coeff_* port.
// The full-precision sum is shifted, saturated, optionally decimated and
// held in a single output register that honours downstream backpressure.
module fir_axis_param #(
    parameter int DATA_W    = 16,
    parameter int COEFF_W   = 8,
    parameter int NUM_TAPS  = 15,
    parameter int OUT_W     = 24,
    parameter int OUT_SHIFT = 0,
    parameter int DECIM     = 1
) (
    input  logic                        s00_axis_aclk,
    input  logic                        s00_axis_aresetn,
    fir_axis_param_if.slave             s00_axis,
    fir_axis_param_if.master            m00_axis,
    input  logic                        cfg_coeff_wen,
    input  logic [$clog2(NUM_TAPS)-1:0] cfg_coeff_addr,
    input  logic signed [COEFF_W-1:0]   cfg_coeff_data,
    input  logic                        cfg_clear,
    output logic                        sat_flag
);

    // Accumulator width: products plus enough headroom for NUM_TAPS terms.
    localparam int ACC_W = DATA_W + COEFF_W + $clog2(NUM_TAPS);
    // Saturation compare width must hold both the sum and the output range.
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic signed [CMP_W-1:0] SAT_MAX =
        {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [CMP_W-1:0] SAT_MIN =
        {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Sign-extend both operands to ACC_W so the product is exact at that width.
    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic signed [COEFF_W-1:0] c,
        input logic signed [DATA_W-1:0]  x
    );
        logic signed [ACC_W-1:0] ce;
        logic signed [ACC_W-1:0] xe;
        ce = ACC_W'(c);
        xe = ACC_W'(x);
        return ce * xe;
    endfunction

    logic signed [COEFF_W-1:0] coeff_r [NUM_TAPS];
    // acc[0] would never be read: the output tap is formed combinationally.
    logic signed [ACC_W-1:0]   acc_r   [1:NUM_TAPS-1];
    logic [PH_W-1:0]           phase_r;
    logic [OUT_W-1:0]          tdata_r;
    logic                      tvalid_r;
    logic                      tlast_r;
    logic                      sat_r;

    logic signed [DATA_W-1:0]  x_s;
    logic signed [ACC_W-1:0]   prod_s [NUM_TAPS];
    logic signed [ACC_W-1:0]   y_s;
    logic signed [ACC_W-1:0]   shifted_s;
    logic signed [CMP_W-1:0]   wide_s;
    logic signed [OUT_W-1:0]   sat_val_s;
    logic                      clip_s;
    logic                      emit_s;
    logic [PH_W-1:0]           phase_nxt_s;
    logic                      tready_s;
    logic                      accept_s;

    assign x_s      = s00_axis.tdata;
    assign tready_s = (~tvalid_r | m00_axis.tready) & ~cfg_clear;
    assign accept_s = s00_axis.tvalid & tready_s;

    assign s00_axis.tready = tready_s;
    assign m00_axis.tdata  = tdata_r;
    assign m00_axis.tvalid = tvalid_r;
    assign m00_axis.tlast  = tlast_r;
    assign m00_axis.tstrb  = {(OUT_W/8){1'b1}};
    assign sat_flag        = sat_r;

    // Per-tap products of the current input sample with the current coefficients.
    always_comb begin
        for (int i = 0; i < NUM_TAPS; i++) begin
            prod_s[i] = mul_ext(coeff_r[i], x_s);
        end
    end

    // Output tap, arithmetic shift and saturation to the OUT_W range.
    always_comb begin
        y_s       = prod_s[0] + acc_r[1];
        shifted_s = y_s >>> OUT_SHIFT;
        wide_s    = CMP_W'(shifted_s);
        if (wide_s > SAT_MAX) begin
            sat_val_s = {1'b0, {(OUT_W-1){1'b1}}};
            clip_s    = 1'b1;
        end else if (wide_s < SAT_MIN) begin
            sat_val_s = {1'b1, {(OUT_W-1){1'b0}}};
            clip_s    = 1'b1;
        end else begin
            sat_val_s = OUT_W'(wide_s);
            clip_s    = 1'b0;
        end
    end

    // Decimation: emit on phase 0 or end of packet; tlast re-aligns the phase.
    always_comb begin
        emit_s = (phase_r == {PH_W{1'b0}}) | s00_axis.tlast;
        if (s00_axis.tlast) begin
            phase_nxt_s = {PH_W{1'b0}};
        end else if (32'(phase_r) >= 32'(DECIM - 1)) begin
            phase_nxt_s = {PH_W{1'b0}};
        end else begin
            phase_nxt_s = phase_r + PH_W'(1'b1);
        end
    end

    // Coefficient bank: impulse after reset, out-of-range addresses dropped.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coeff_r[i] <= (i == 0) ? {{(COEFF_W-1){1'b0}}, 1'b1}
                                       : {COEFF_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                if (cfg_coeff_wen && (32'(cfg_coeff_addr) == 32'(i))) begin
                    coeff_r[i] <= cfg_coeff_data;
                end
            end
        end
    end

    // Transposed delay line: advances only on an accepted input sample.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            for (int i = 1; i < NUM_TAPS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (cfg_clear) begin
            for (int i = 1; i < NUM_TAPS; i++) begin
                acc_r[i] <= {ACC_W{1'b0}};
            end
        end else if (accept_s) begin
            for (int i = 1; i < NUM_TAPS - 1; i++) begin
                acc_r[i] <= prod_s[i] + acc_r[i+1];
            end
            acc_r[NUM_TAPS-1] <= prod_s[NUM_TAPS-1];
        end
    end

    // Decimation phase counter.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            phase_r <= {PH_W{1'b0}};
        end else if (cfg_clear) begin
            phase_r <= {PH_W{1'b0}};
        end else if (accept_s) begin
            phase_r <= phase_nxt_s;
        end
    end

    // Output register: load on an emitting accept, else drop valid once taken.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            tdata_r  <= {OUT_W{1'b0}};
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
        end else if (accept_s && emit_s) begin
            tdata_r  <= sat_val_s;
            tvalid_r <= 1'b1;
            tlast_r  <= s00_axis.tlast;
        end else if (m00_axis.tready) begin
            tvalid_r <= 1'b0;
        end
    end

    // Sticky saturation indicator, cleared only by reset or cfg_clear.
    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            sat_r <= 1'b0;
        end else if (cfg_clear) begin
            sat_r <= 1'b0;
        end else if (accept_s && emit_s && clip_s) begin
            sat_r <= 1'b1;
        end
    end

endmodule
